// File: rtl/branch_predictor.sv
// Bimodal branch predictor: fetch-stage PHT lookup of 2-bit saturating counters, stage-3 training.
// Define BRANCH_PREDICTOR_GSHARE_EN to XOR a non-speculative global history register into the index.
module branch_predictor #(
    parameter int IDX_W = 6,
    parameter int PC_W  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [PC_W-1:0]  fetch_pc,
    output logic             pred_taken,
    output logic [IDX_W-1:0] pred_idx,
    input  logic [1:0]       branch3,
    input  logic             alu_zero,
    input  logic             prediction3,
    input  logic [IDX_W-1:0] idx3,
    input  logic             exception,
    output logic             mispredict,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam int DEPTH = 1 << IDX_W;

    function automatic logic [1:0] pht_step(input logic [1:0] cnt, input logic up);
        logic [1:0] nxt;
        if (up) begin
            nxt = (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        end else begin
            nxt = (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
        end
        return nxt;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1'b1);
    endfunction

    logic [1:0]       pht_q [DEPTH];
    logic [1:0]       pht_d [DEPTH];
    logic [CNT_W-1:0] branch_cnt_q, branch_cnt_d;
    logic [CNT_W-1:0] mispred_cnt_q, mispred_cnt_d;
    logic [IDX_W-1:0] hist_s;
    logic             is_br_s;
    logic             taken_s;
    logic             train_s;
    logic             unused_pc_s;

    assign unused_pc_s = ^{fetch_pc[PC_W-1:IDX_W+2], fetch_pc[1:0]};

`ifdef BRANCH_PREDICTOR_GSHARE_EN
    logic [IDX_W-1:0] ghr_q, ghr_d;

    // History shifts in resolved outcomes only, so it never needs repair on a flush.
    always_comb begin
        ghr_d = ghr_q;
        if (train_s) begin
            ghr_d = {ghr_q[IDX_W-2:0], taken_s};
        end else begin
            ghr_d = ghr_q;
        end
    end

    // Global history register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ghr_q <= {IDX_W{1'b0}};
        end else begin
            ghr_q <= ghr_d;
        end
    end

    assign hist_s = ghr_q;
`else
    assign hist_s = {IDX_W{1'b0}};
`endif

    // Resolve the stage-3 branch and derive the flush/training conditions.
    always_comb begin
        is_br_s    = 1'b0;
        taken_s    = 1'b0;
        case (branch3)
            2'b01: begin
                is_br_s = 1'b1;
                taken_s = alu_zero;
            end
            2'b11: begin
                is_br_s = 1'b1;
                taken_s = ~alu_zero;
            end
            default: begin
                is_br_s = 1'b0;
                taken_s = 1'b0;
            end
        endcase
        train_s    = is_br_s & ~exception;
        mispredict = train_s & (taken_s != prediction3);
    end

    // Fetch lookup reads the registered table, so a same-cycle train is seen one cycle later.
    always_comb begin
        pred_idx   = fetch_pc[IDX_W+1:2] ^ hist_s;
        pred_taken = pht_q[pred_idx][1];
    end

    // Next-state for the table and the saturating performance counters.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            pht_d[i] = pht_q[i];
        end
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (train_s) begin
            pht_d[idx3]  = pht_step(pht_q[idx3], taken_s);
            branch_cnt_d = sat_inc(branch_cnt_q);
        end else begin
            pht_d[idx3]  = pht_q[idx3];
            branch_cnt_d = branch_cnt_q;
        end
        if (mispredict) begin
            mispred_cnt_d = sat_inc(mispred_cnt_q);
        end else begin
            mispred_cnt_d = mispred_cnt_q;
        end
    end

    // Table and counter state; reset leaves every entry weakly not-taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                pht_q[i] <= 2'b01;
            end
            branch_cnt_q  <= {CNT_W{1'b0}};
            mispred_cnt_q <= {CNT_W{1'b0}};
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                pht_q[i] <= pht_d[i];
            end
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    assign branch_cnt  = branch_cnt_q;
    assign mispred_cnt = mispred_cnt_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Self-checking bench for branch_predictor: directed vector table, reset corner cases, random vs. model.
module tb_branch_predictor;

    localparam int IDX_W = 6;
    localparam int PC_W  = 32;
    localparam int CNT_W = 8;
    localparam int CMAX  = (1 << CNT_W) - 1;
    localparam int DEPTH = 1 << IDX_W;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [PC_W-1:0]  fetch_pc;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_idx;
    logic [1:0]       branch3;
    logic             alu_zero;
    logic             prediction3;
    logic [IDX_W-1:0] idx3;
    logic             exception;
    logic             mispredict;
    logic [CNT_W-1:0] branch_cnt;
    logic [CNT_W-1:0] mispred_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: plain integers, strength 0..3, counts clamp at CMAX.
    int m_pht [DEPTH];
    int m_bcnt, m_mcnt, m_ghr;

    branch_predictor #(.IDX_W(IDX_W), .PC_W(PC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst_n(rst_n), .fetch_pc(fetch_pc), .pred_taken(pred_taken),
        .pred_idx(pred_idx), .branch3(branch3), .alu_zero(alu_zero),
        .prediction3(prediction3), .idx3(idx3), .exception(exception),
        .mispredict(mispredict), .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  br;
        logic        az;
        logic        p3;
        logic [5:0]  i3;
        logic        exc;
        logic        e_pred;
        logic [5:0]  e_idx;
        logic        e_misp;
        int          e_bcnt;
        int          e_mcnt;
    } vec_t;

    function automatic vec_t mk(logic [31:0] pc, logic [1:0] br, logic az, logic p3, logic [5:0] i3,
                                logic exc, logic ep, logic [5:0] ei, logic em, int eb, int emc);
        vec_t v;
        v.pc = pc; v.br = br; v.az = az; v.p3 = p3; v.i3 = i3; v.exc = exc;
        v.e_pred = ep; v.e_idx = ei; v.e_misp = em; v.e_bcnt = eb; v.e_mcnt = emc;
        return v;
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [31:0] pc, input logic [1:0] br, input logic az,
                         input logic p3, input logic [5:0] i3, input logic exc);
        fetch_pc = pc; branch3 = br; alu_zero = az; prediction3 = p3; idx3 = i3; exception = exc;
    endtask

    task automatic model_reset();
        for (int i = 0; i < DEPTH; i++) m_pht[i] = 1;
        m_bcnt = 0; m_mcnt = 0; m_ghr = 0;
    endtask

    function automatic bit m_is_br();
        return (branch3 == 2'b01) || (branch3 == 2'b11);
    endfunction

    function automatic bit m_taken();
        return (branch3 == 2'b01) ? alu_zero : ((branch3 == 2'b11) ? !alu_zero : 1'b0);
    endfunction

    function automatic bit m_misp();
        return m_is_br() && !exception && (m_taken() != prediction3);
    endfunction

    // Apply the training rules of the current inputs to the model (call at the clock edge).
    task automatic model_clock();
        int t;
        if (rst_n && m_is_br() && !exception) begin
            t = int'(m_taken());
            if (t == 1) m_pht[idx3] = (m_pht[idx3] == 3) ? 3 : m_pht[idx3] + 1;
            else        m_pht[idx3] = (m_pht[idx3] == 0) ? 0 : m_pht[idx3] - 1;
            if (m_misp()) m_mcnt = (m_mcnt == CMAX) ? CMAX : m_mcnt + 1;
            m_bcnt = (m_bcnt == CMAX) ? CMAX : m_bcnt + 1;
`ifdef BRANCH_PREDICTOR_GSHARE_EN
            m_ghr = ((m_ghr * 2) + t) % DEPTH;
`endif
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic check_model(input string tag);
        int idx;
        idx = (int'(fetch_pc / 4) % DEPTH) ^ m_ghr;
        chk({tag, "_idx"}, int'(pred_idx), idx);
        chk({tag, "_pred"}, int'(pred_taken), int'(m_pht[idx] >= 2));
        chk({tag, "_misp"}, int'(mispredict), int'(m_misp()));
        chk({tag, "_bcnt"}, int'(branch_cnt), m_bcnt);
        chk({tag, "_mcnt"}, int'(mispred_cnt), m_mcnt);
    endtask

    vec_t tbl [16];

    initial begin
        logic [31:0] rpc;
        rst_n = 1'b0;
        drive(32'h40, 2'b00, 1'b0, 1'b0, 6'h00, 1'b0);
        model_reset();
        #2;
        chk("rst_pred", int'(pred_taken), 0);
        chk("rst_idx", int'(pred_idx), 'h10);
        chk("rst_bcnt", int'(branch_cnt), 0);
        chk("rst_mcnt", int'(mispred_cnt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

`ifndef BRANCH_PREDICTOR_GSHARE_EN
        // pc, br, az, p3, idx3, exc | pred, idx, misp, bcnt, mcnt (counts before this cycle's edge)
        tbl[0]  = mk(32'h40, 2'b00, 1'b0, 1'b0, 6'h10, 1'b0, 1'b0, 6'h10, 1'b0, 0, 0);
        tbl[1]  = mk(32'h40, 2'b01, 1'b1, 1'b0, 6'h10, 1'b0, 1'b0, 6'h10, 1'b1, 0, 0);
        tbl[2]  = mk(32'h40, 2'b01, 1'b1, 1'b0, 6'h10, 1'b0, 1'b1, 6'h10, 1'b1, 1, 1);
        tbl[3]  = mk(32'h40, 2'b00, 1'b1, 1'b0, 6'h10, 1'b0, 1'b1, 6'h10, 1'b0, 2, 2);
        tbl[4]  = mk(32'h40, 2'b11, 1'b1, 1'b0, 6'h10, 1'b0, 1'b1, 6'h10, 1'b0, 2, 2);
        tbl[5]  = mk(32'h40, 2'b11, 1'b1, 1'b0, 6'h10, 1'b0, 1'b1, 6'h10, 1'b0, 3, 2);
        tbl[6]  = mk(32'h40, 2'b11, 1'b1, 1'b0, 6'h10, 1'b0, 1'b0, 6'h10, 1'b0, 4, 2);
        tbl[7]  = mk(32'h40, 2'b11, 1'b1, 1'b0, 6'h10, 1'b0, 1'b0, 6'h10, 1'b0, 5, 2);
        tbl[8]  = mk(32'h40, 2'b00, 1'b0, 1'b0, 6'h10, 1'b0, 1'b0, 6'h10, 1'b0, 6, 2);
        tbl[9]  = mk(32'h40, 2'b01, 1'b1, 1'b0, 6'h10, 1'b1, 1'b0, 6'h10, 1'b0, 6, 2);
        tbl[10] = mk(32'h40, 2'b00, 1'b0, 1'b0, 6'h10, 1'b0, 1'b0, 6'h10, 1'b0, 6, 2);
        tbl[11] = mk(32'h40, 2'b10, 1'b0, 1'b1, 6'h10, 1'b0, 1'b0, 6'h10, 1'b0, 6, 2);
        tbl[12] = mk(32'h40, 2'b00, 1'b0, 1'b1, 6'h10, 1'b0, 1'b0, 6'h10, 1'b0, 6, 2);
        tbl[13] = mk(32'h40, 2'b01, 1'b1, 1'b1, 6'h10, 1'b0, 1'b0, 6'h10, 1'b0, 6, 2);
        tbl[14] = mk(32'h40, 2'b00, 1'b0, 1'b0, 6'h10, 1'b0, 1'b0, 6'h10, 1'b0, 7, 2);
        tbl[15] = mk(32'h44, 2'b00, 1'b0, 1'b0, 6'h10, 1'b0, 1'b0, 6'h11, 1'b0, 7, 2);
        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].pc, tbl[i].br, tbl[i].az, tbl[i].p3, tbl[i].i3, tbl[i].exc);
            @(negedge clk);
            chk($sformatf("vec%0d_pred", i), int'(pred_taken), int'(tbl[i].e_pred));
            chk($sformatf("vec%0d_idx", i), int'(pred_idx), int'(tbl[i].e_idx));
            chk($sformatf("vec%0d_misp", i), int'(mispredict), int'(tbl[i].e_misp));
            chk($sformatf("vec%0d_bcnt", i), int'(branch_cnt), tbl[i].e_bcnt);
            chk($sformatf("vec%0d_mcnt", i), int'(mispred_cnt), tbl[i].e_mcnt);
            tick();
        end

        // Read-before-write on the same index, then reset with a train pending.
        drive(32'h14, 2'b01, 1'b1, 1'b0, 6'h05, 1'b0);
        @(negedge clk);
        chk("rbw_old", int'(pred_taken), 0);
        chk("rbw_misp", int'(mispredict), 1);
        tick();
        drive(32'h80, 2'b01, 1'b1, 1'b0, 6'h20, 1'b0);
        @(negedge clk);
        chk("e20_old", int'(pred_taken), 0);
        tick();
        drive(32'h14, 2'b00, 1'b0, 1'b0, 6'h00, 1'b0);
        #1 chk("rbw_new", int'(pred_taken), 1);
        drive(32'h80, 2'b00, 1'b0, 1'b0, 6'h00, 1'b0);
        #1 chk("e20_new", int'(pred_taken), 1);
        drive(32'h14, 2'b01, 1'b1, 1'b1, 6'h05, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("mid_rst_pred", int'(pred_taken), 0);
        chk("mid_rst_bcnt", int'(branch_cnt), 0);
        chk("mid_rst_mcnt", int'(mispred_cnt), 0);
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        drive(32'h14, 2'b00, 1'b0, 1'b0, 6'h00, 1'b0);
        #1 chk("post_rst_e05", int'(pred_taken), 0);
        drive(32'h80, 2'b00, 1'b0, 1'b0, 6'h00, 1'b0);
        #1 chk("post_rst_e20", int'(pred_taken), 0);
        chk("post_rst_bcnt", int'(branch_cnt), 0);
        tick();
`else
        for (int i = 0; i < 3; i++) begin
            drive(32'h0, 2'b01, 1'b1, 1'b1, 6'h00, 1'b0);
            tick();
        end
        drive(32'h40, 2'b00, 1'b0, 1'b0, 6'h00, 1'b0);
        #1 chk("gshare_idx", int'(pred_idx), 'h17);
        check_model("gshare");
        tick();
`endif

        // Random traffic over a handful of hot indices; second half forces mostly mispredicts.
        for (int n = 0; n < 1200; n++) begin
            rpc = $urandom;
            rpc[7:2] = 6'($urandom_range(0, 7));
            drive(rpc, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  6'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0));
            if (n >= 500 && $urandom_range(0, 9) < 8) prediction3 = !m_taken();
            @(negedge clk);
            check_model("rnd");
            tick();
        end
        chk("bcnt_saturated", int'(branch_cnt), CMAX);
        chk("mcnt_saturated", int'(mispred_cnt), CMAX);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
